// File: rtl/imem_loader.sv
// Boot-time instruction-memory loader: parses a 16-bit word-count header and
// writes big-endian 32-bit words from address 0. Optional trailer check: IMEM_LOADER_CSUM_EN.
module imem_loader #(
  parameter int ADDR_W    = 8,
  parameter int MAX_WORDS = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic              cpu_hold
);

  // state  | meaning
  // IDLE   | waiting for start after reset
  // HDR_HI | accepting word-count high byte
  // HDR_LO | accepting word-count low byte, range check
  // DATA   | accepting the four bytes of a word, MSB first
  // WRITE  | one-cycle memory write, advance index
  // CSUM   | accepting the XOR trailer byte (checksum build only)
  // DONE   | image loaded, CPU released
  // ERR    | session aborted, CPU held
  typedef enum logic [2:0] {
    IDLE, HDR_HI, HDR_LO, DATA, WRITE, DONE, ERR
`ifdef IMEM_LOADER_CSUM_EN
    , CSUM
`endif
  } state_t;

  localparam int IW = ADDR_W + 1;

`ifdef IMEM_LOADER_CSUM_EN
  localparam state_t FINISH = CSUM;
  logic [7:0] csum;
`else
  localparam state_t FINISH = DONE;
`endif

  state_t        state, state_d;
  logic [7:0]    n_hi;
  logic [IW-1:0] n_words;
  logic [IW-1:0] idx;
  logic [IW-1:0] idx_inc;
  logic [1:0]    bcnt;
  logic [31:0]   word;
  logic [15:0]   hdr_n;
  logic          xfer;

  assign xfer    = byte_valid && byte_ready;
  assign hdr_n   = {n_hi, byte_data};
  assign idx_inc = idx + 1'b1;

  always_comb begin
    state_d = state;
    case (state)
      IDLE, DONE, ERR: if (start) state_d = HDR_HI;
      HDR_HI: if (xfer) state_d = HDR_LO;
      HDR_LO: begin
        if (xfer) begin
          if (hdr_n == 16'd0)                 state_d = FINISH;
          else if (int'(hdr_n) > MAX_WORDS)   state_d = ERR;
          else                                state_d = DATA;
        end
      end
      DATA:  if (xfer && bcnt == 2'd3) state_d = WRITE;
      WRITE: state_d = (idx_inc == n_words) ? FINISH : DATA;
`ifdef IMEM_LOADER_CSUM_EN
      CSUM:  if (xfer) state_d = (byte_data == csum) ? DONE : ERR;
`endif
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    byte_ready = 1'b0;
    busy       = 1'b0;
    case (state)
      HDR_HI, HDR_LO, DATA: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
      end
`ifdef IMEM_LOADER_CSUM_EN
      CSUM: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
      end
`endif
      WRITE:   busy = 1'b1;
      default: ;
    endcase
  end

  // Status flags are pure state decodes so an async reset clears them at once.
  assign imem_we    = (state == WRITE);
  assign done       = (state == DONE);
  assign error      = (state == ERR);
  assign cpu_hold   = (state != DONE);
  assign imem_addr  = idx[ADDR_W-1:0];
  assign imem_wdata = word;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      n_hi    <= '0;
      n_words <= '0;
      idx     <= '0;
      bcnt    <= '0;
      word    <= '0;
`ifdef IMEM_LOADER_CSUM_EN
      csum    <= '0;
`endif
    end else begin
      state <= state_d;
      case (state)
        IDLE, DONE, ERR: begin
          if (start) begin
            idx  <= '0;
            bcnt <= '0;
`ifdef IMEM_LOADER_CSUM_EN
            csum <= '0;
`endif
          end
        end
        HDR_HI: if (xfer) n_hi <= byte_data;
        HDR_LO: if (xfer) n_words <= hdr_n[IW-1:0];
        DATA: begin
          if (xfer) begin
            word <= {word[23:0], byte_data};
            bcnt <= bcnt + 2'd1;
`ifdef IMEM_LOADER_CSUM_EN
            csum <= csum ^ byte_data;
`endif
          end
        end
        WRITE:   idx <= idx_inc;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: driver pushes expected writes, a negedge
// monitor pops and checks address, data and write latency.
module tb_imem_loader;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = 8'h00;
  logic        byte_ready, imem_we, busy, done, error, cpu_hold;
  logic [7:0]  imem_addr;
  logic [31:0] imem_wdata;

  imem_loader #(.ADDR_W(8), .MAX_WORDS(256)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .busy(busy), .done(done), .error(error), .cpu_hold(cpu_hold)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int passed = 0;
  int hs_cyc = 0;

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] data;
    int          cyc;
  } wr_t;
  wr_t        exp_q[$];
  logic [7:0] stim[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  always @(negedge clk) begin
    wr_t e;
    if (rst_n && imem_we) begin
      if (exp_q.size() == 0) begin
        total++;
        $display("FAIL unexpected_write: addr %h data %h, no write expected", imem_addr, imem_wdata);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", 32'(imem_addr), 32'(e.addr));
        chk("wr_data", imem_wdata, e.data);
        chk("wr_latency", cyc, e.cyc);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit rnd);
    int  t;
    bit  sent;
    t = 0;
    sent = 0;
    while (!sent) begin
      @(negedge clk);
      byte_data  = b;
      byte_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (byte_valid && byte_ready) begin
        @(posedge clk);
        hs_cyc = cyc;
        sent = 1;
      end else begin
        t++;
        if (t > 200) begin
          total++;
          $display("FAIL handshake_timeout: byte %h not accepted, ready=%b", b, byte_ready);
          sent = 1;
        end
      end
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    byte_valid = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Reference: N from the header, word i = bytes 2+4i..5+4i big-endian,
  // success iff N <= 256 (and, with checksum, trailer equals XOR of data bytes).
  task automatic play(input bit rnd, input int tr);
    int          n;
    bit          exp_ok;
    logic [7:0]  x;
    logic [7:0]  t;
    logic [31:0] w;
    n = int'({stim[0], stim[1]});
    x = 8'h00;
    exp_ok = (n <= 256);
    pulse_start();
    send_byte(stim[0], rnd);
    send_byte(stim[1], rnd);
    if (n <= 256) begin
      for (int i = 0; i < n; i++) begin
        w = {stim[2+4*i], stim[3+4*i], stim[4+4*i], stim[5+4*i]};
        for (int k = 0; k < 4; k++) begin
          send_byte(stim[2+4*i+k], rnd);
          x = x ^ stim[2+4*i+k];
        end
        exp_q.push_back('{addr: 8'(i), data: w, cyc: hs_cyc + 1});
      end
`ifdef IMEM_LOADER_CSUM_EN
      t = (tr < 0) ? x : 8'(tr);
      send_byte(t, rnd);
      exp_ok = (t == x);
`else
      t = 8'(tr);
`endif
    end
    @(negedge clk);
    byte_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("end_done", 32'(done), 32'(exp_ok));
    chk("end_error", 32'(error), 32'(!exp_ok));
    chk("end_cpu_hold", 32'(cpu_hold), 32'(!exp_ok));
    chk("end_busy", 32'(busy), 32'd0);
    chk("end_byte_ready", 32'(byte_ready), 32'd0);
    chk("pending_writes", exp_q.size(), 32'd0);
    exp_q.delete();
  endtask

  task automatic rand_stim(input int n);
    stim.delete();
    stim.push_back(8'(n >> 8));
    stim.push_back(8'(n));
    for (int i = 0; i < 4 * n; i++) stim.push_back(8'($urandom_range(0, 255)));
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_byte_ready"}, 32'(byte_ready), 32'd0);
    chk({tag, "_imem_we"}, 32'(imem_we), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_error"}, 32'(error), 32'd0);
    chk({tag, "_cpu_hold"}, 32'(cpu_hold), 32'd1);
    chk({tag, "_addr"}, 32'(imem_addr), 32'd0);
    chk({tag, "_wdata"}, imem_wdata, 32'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk_reset_outputs("idle");

    stim = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'hAC, 8'h08, 8'h00, 8'h04};
    play(0, -1);
    play(1, -1);

    stim = '{8'h01, 8'h01};
    play(0, -1);
    stim = '{8'h00, 8'h00};
    play(0, -1);

    for (int s = 0; s < 4; s++) begin
      rand_stim($urandom_range(1, 6));
      play(1, -1);
    end
    rand_stim(256);
    play(0, -1);
    stim = '{8'h01, 8'h00};
    play(0, -1);
    for (int i = 0; i < 1024; i++) stim.push_back(8'($urandom_range(0, 255)));
    play(0, -1);

    stim = '{8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h02, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    @(negedge clk);
    byte_valid = 1'b0;
    chk("pre_reset_busy", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    play(0, -1);

`ifdef IMEM_LOADER_CSUM_EN
    stim = '{8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44};
    play(0, 8'h44);
    play(0, 8'h45);
    rand_stim(3);
    play(1, -1);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, %0d/%0d passed", passed, total);
    $fatal(1);
  end

endmodule
